// File: rtl/imem_loadable_if.sv
// Program-load and fetch request/response bundle for imem_loadable.
// The master side (core or loader) drives the requests; the slave side (memory) drives the responses.
interface imem_loadable_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              prog_en;
    logic [ADDR_W:0]   prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_done;
    logic [ADDR_W:0]   loaded_count;
    logic              running;

    logic              fetch_valid;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [31:0]       instr_pc;
    logic              instr_fault;

    modport master (
        output prog_en, prog_addr, prog_data, prog_done,
        output fetch_valid, fetch_addr, instr_ready,
        input  loaded_count, running, fetch_ready,
        input  instr_valid, instr, instr_pc, instr_fault
    );

    modport slave (
        input  prog_en, prog_addr, prog_data, prog_done,
        input  fetch_valid, fetch_addr, instr_ready,
        output loaded_count, running, fetch_ready,
        output instr_valid, instr, instr_pc, instr_fault
    );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: a LOAD phase fills the array, then RUN serves fetches
// with a one-entry registered response that carries a fault flag.
module imem_loadable #(
    parameter int unsigned      DEPTH    = 32,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000000)
) (
    input logic            clk,
    input logic            rst,
    imem_loadable_if.slave bus
);

    localparam int unsigned      CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  loaded_count_q, loaded_count_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [31:0]       instr_pc_q, instr_pc_d;
    logic              instr_fault_q, instr_fault_d;

    // Not reset: the program survives rst and is re-used after the next prog_done.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              running_c;
    logic              wr_en_c;
    logic              fault_c;
    logic              fetch_ready_c;
    logic              accept_c;
    logic [ADDR_W-1:0] rd_idx_c;

    always_comb begin
        running_c     = (state_q == ST_RUN);
        wr_en_c       = !running_c && bus.prog_en && (bus.prog_addr < DEPTH_CNT);
        fault_c       = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr[31:2] >= DEPTH_WORDS);
        rd_idx_c      = bus.fetch_addr[ADDR_W+1:2];
        fetch_ready_c = running_c && (!instr_valid_q || bus.instr_ready);
        accept_c      = bus.fetch_valid && fetch_ready_c;
    end

    // Next-state for the phase FSM, the program counter of accepted writes and the response slot.
    always_comb begin
        state_d        = state_q;
        loaded_count_d = loaded_count_q;
        instr_valid_d  = instr_valid_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_fault_d  = instr_fault_q;

        if (state_q == ST_LOAD && bus.prog_done) begin
            state_d = ST_RUN;
        end

        if (wr_en_c && (loaded_count_q != DEPTH_CNT)) begin
            loaded_count_d = loaded_count_q + CNT_W'(1);
        end

        if (accept_c) begin
            instr_valid_d = 1'b1;
            instr_pc_d    = bus.fetch_addr;
            instr_fault_d = fault_c;
            if (fault_c) begin
                instr_d = NOP_WORD;
            end else begin
                instr_d = mem_q[rd_idx_c];
            end
        end else if (instr_valid_q && bus.instr_ready) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_LOAD;
            loaded_count_q <= '0;
            instr_valid_q  <= 1'b0;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            instr_fault_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            loaded_count_q <= loaded_count_d;
            instr_valid_q  <= instr_valid_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            instr_fault_q  <= instr_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[bus.prog_addr[ADDR_W-1:0]] <= bus.prog_data;
        end
    end

    assign bus.running      = running_c;
    assign bus.loaded_count = loaded_count_q;
    assign bus.fetch_ready  = fetch_ready_c;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.instr_fault  = instr_fault_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed load/fetch table, multi-cycle corner
// sequences, and a randomized fetch phase against a behavioural response model.
module tb_imem_loadable;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam logic [31:0] NOP    = 32'h00000000;
    localparam logic [31:0] W0     = 32'h02328020;
    localparam logic [31:0] W1     = 32'h8C080004;
    localparam logic [31:0] W5     = 32'h2405000A;
    localparam logic [31:0] W31    = 32'h03E00008;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          mdl_cnt;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_fault;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [8];

    imem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_loadable #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [ADDR_W:0] a, input logic [31:0] d);
        bus.prog_en   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        step();
        bus.prog_en = 1'b0;
        if (int'(a) < DEPTH) begin
            mdl_mem[a[ADDR_W-1:0]] = d;
            if (mdl_cnt < DEPTH) mdl_cnt++;
        end
    endtask

    function automatic logic addr_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic fetch_one(input logic [31:0] a);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = a;
        bus.instr_ready = 1'b1;
        step();
        bus.fetch_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, W0,  1'b0};
        vecs[1] = '{32'h0000_0004, W1,  1'b0};
        vecs[2] = '{32'h0000_0002, NOP, 1'b1};
        vecs[3] = '{32'h0000_0080, NOP, 1'b1};
        vecs[4] = '{32'h0000_0014, W5,  1'b0};
        vecs[5] = '{32'hFFFF_FFFC, NOP, 1'b1};
        vecs[6] = '{32'h0000_007C, W31, 1'b0};
        vecs[7] = '{32'h0000_0007, NOP, 1'b1};

        mdl_cnt         = 0;
        bus.prog_en     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        bus.prog_done   = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;
        bus.instr_ready = 1'b0;

        // Reset values, before any clock edge.
        #3;
        chk("rst_running",     32'(bus.running),      32'd0);
        chk("rst_loaded",      32'(bus.loaded_count), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid),  32'd0);
        chk("rst_instr",       bus.instr,             32'd0);
        chk("rst_instr_pc",    bus.instr_pc,          32'd0);
        chk("rst_instr_fault", 32'(bus.instr_fault),  32'd0);
        chk("rst_fetch_ready", 32'(bus.fetch_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // LOAD phase: fetch requests are not accepted.
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0;
        bus.instr_ready = 1'b1;
        #1;
        chk("load_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        prog_write(6'd0, W0);
        prog_write(6'd1, W1);
        chk("load_count_2", 32'(bus.loaded_count), 32'(mdl_cnt));
        chk("load_count_2_const", 32'(bus.loaded_count), 32'd2);
        prog_write(6'(DEPTH), 32'hBAD0_BAD0);
        chk("load_oob_ignored", 32'(bus.loaded_count), 32'd2);
        for (int i = 0; i <= int'(DEPTH); i++) prog_write(6'd3, $urandom());
        chk("load_count_sat", 32'(bus.loaded_count), 32'(DEPTH));
        for (int i = 2; i < int'(DEPTH); i++) prog_write(6'(i), $urandom());
        prog_write(6'd31, W31);
        chk("load_count_hold", 32'(bus.loaded_count), 32'(mdl_cnt));
        chk("load_no_response", 32'(bus.instr_valid), 32'd0);
        chk("load_running", 32'(bus.running), 32'd0);
        bus.fetch_valid = 1'b0;

        // prog_done together with a write: the write lands.
        bus.prog_done = 1'b1;
        prog_write(6'd5, W5);
        bus.prog_done = 1'b0;
        chk("run_running", 32'(bus.running), 32'd1);
        chk("run_no_stale_fetch", 32'(bus.instr_valid), 32'd0);

        // Directed fetch table, back to back with instr_ready held high.
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_valid = 1'b1;
            bus.fetch_addr  = vecs[i].addr;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(bus.fetch_ready), 32'd1);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'd1);
            chk($sformatf("tbl%0d_instr", i), bus.instr,            vecs[i].exp_instr);
            chk($sformatf("tbl%0d_pc", i),    bus.instr_pc,         vecs[i].addr);
            chk($sformatf("tbl%0d_fault", i), 32'(bus.instr_fault), 32'(vecs[i].exp_fault));
        end
        bus.fetch_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.instr_valid), 32'd0);

        // Writes in RUN are ignored.
        bus.prog_done = 1'b1;
        bus.prog_en   = 1'b1;
        bus.prog_addr = 6'd0;
        bus.prog_data = 32'hDEAD_BEEF;
        step();
        bus.prog_en   = 1'b0;
        bus.prog_done = 1'b0;
        chk("run_write_count", 32'(bus.loaded_count), 32'(DEPTH));
        fetch_one(32'h0);
        chk("run_write_ignored", bus.instr, W0);

        // Back-pressure: response holds for three cycles, queued fetch taken on release.
        fetch_one(32'h4);
        chk("bp_first", bus.instr, W1);
        bus.instr_ready = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_ready", i), 32'(bus.fetch_ready), 32'd0);
            step();
            chk($sformatf("bp%0d_valid", i), 32'(bus.instr_valid), 32'd1);
            chk($sformatf("bp%0d_instr", i), bus.instr,            W1);
            chk($sformatf("bp%0d_pc", i),    bus.instr_pc,         32'h4);
        end
        bus.instr_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.fetch_ready), 32'd1);
        step();
        chk("bp_release_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_release_instr", bus.instr,            W0);
        chk("bp_release_pc",    bus.instr_pc,         32'h0);
        bus.fetch_valid = 1'b0;
        step();
        chk("bp_drain", 32'(bus.instr_valid), 32'd0);

        // Randomized fetches against the response model.
        m_valid = 1'b0;
        m_instr = '0;
        m_pc    = '0;
        m_fault = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        fv, rdy, exp_ready;
            logic [31:0] a;
            int          r;
            fv  = 1'($urandom_range(0, 3) != 0);
            rdy = 1'($urandom_range(0, 3) != 0);
            r   = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else             a = $urandom() | 32'h80;
            bus.fetch_valid = fv;
            bus.fetch_addr  = a;
            bus.instr_ready = rdy;
            #1;
            exp_ready = !m_valid || rdy;
            chk("rnd_ready", 32'(bus.fetch_ready), 32'(exp_ready));
            step();
            if (fv && exp_ready) begin
                m_valid = 1'b1;
                m_fault = addr_fault(a);
                m_instr = m_fault ? NOP : mdl_mem[a / 4];
                m_pc    = a;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            chk("rnd_valid", 32'(bus.instr_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_instr", bus.instr,            m_instr);
                chk("rnd_pc",    bus.instr_pc,         m_pc);
                chk("rnd_fault", 32'(bus.instr_fault), 32'(m_fault));
            end
        end
        bus.fetch_valid = 1'b0;

        // Asynchronous reset with a response in flight.
        fetch_one(32'h4);
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",   32'(bus.instr_valid),  32'd0);
        chk("async_rst_running", 32'(bus.running),      32'd0);
        chk("async_rst_instr",   bus.instr,             32'd0);
        chk("async_rst_count",   32'(bus.loaded_count), 32'd0);
        #1;
        rst = 1'b0;
        bus.prog_done = 1'b1;
        step();
        bus.prog_done = 1'b0;
        chk("rerun_running", 32'(bus.running),      32'd1);
        chk("rerun_count",   32'(bus.loaded_count), 32'd0);
        fetch_one(32'h0);
        chk("rerun_valid", 32'(bus.instr_valid), 32'd1);
        chk("rerun_instr", bus.instr,            W0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
